// File: rtl/pspin_ctrl_csr.sv
`default_nettype none
// ============================================================================
// Module   : pspin_ctrl_csr
// Brief    : AXI-Lite control/status register block for the PsPIN cluster
//            complex. It holds cluster fetch enables, EOC sticky/IRQ logic,
//            MPQ full status, stdout FIFO pops and a double-buffered
//            matching-engine rule table that is updated by an explicit commit.
// Revision : 1.0 - initial release
// ============================================================================
module pspin_ctrl_csr #(
  parameter int ADDR_WIDTH     = 16,
  parameter int NUM_CLUSTERS   = 2,
  parameter int NUM_MPQ        = 256,
  parameter int NUM_STDOUT     = 2,
  parameter int UMATCH_WIDTH   = 32,
  parameter int UMATCH_ENTRIES = 16,
  parameter int UMATCH_MODES   = 2,
  localparam int MODE_W        = (UMATCH_MODES > 1) ? $clog2(UMATCH_MODES) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  // AXI-Lite write address / data / response
  input  logic [ADDR_WIDTH-1:0]                    s_axil_awaddr_i,
  input  logic [2:0]                               s_axil_awprot_i,
  input  logic                                     s_axil_awvalid_i,
  output logic                                     s_axil_awready_o,
  input  logic [31:0]                              s_axil_wdata_i,
  input  logic [3:0]                               s_axil_wstrb_i,
  input  logic                                     s_axil_wvalid_i,
  output logic                                     s_axil_wready_o,
  output logic [1:0]                               s_axil_bresp_o,
  output logic                                     s_axil_bvalid_o,
  input  logic                                     s_axil_bready_i,
  // AXI-Lite read address / data
  input  logic [ADDR_WIDTH-1:0]                    s_axil_araddr_i,
  input  logic [2:0]                               s_axil_arprot_i,
  input  logic                                     s_axil_arvalid_i,
  output logic                                     s_axil_arready_o,
  output logic [31:0]                              s_axil_rdata_o,
  output logic [1:0]                               s_axil_rresp_o,
  output logic                                     s_axil_rvalid_o,
  input  logic                                     s_axil_rready_i,
  // Cluster control / status
  output logic [NUM_CLUSTERS-1:0]                  cl_fetch_en_o,
  output logic                                     aux_rst_o,
  output logic                                     irq_o,
  input  logic [NUM_CLUSTERS-1:0]                  cl_eoc_i,
  input  logic [NUM_CLUSTERS-1:0]                  cl_busy_i,
  input  logic [NUM_MPQ-1:0]                       mpq_full_i,
  // stdout FIFOs
  output logic [NUM_STDOUT-1:0]                    stdout_rd_en_o,
  input  logic [32*NUM_STDOUT-1:0]                 stdout_dout_i,
  input  logic [NUM_STDOUT-1:0]                    stdout_valid_i,
  // Matching engine configuration
  output logic [MODE_W-1:0]                        match_mode_o,
  output logic                                     match_valid_o,
  output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0]   match_idx_o,
  output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0]   match_mask_o,
  output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0]   match_start_o,
  output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0]   match_end_o
);

  localparam int          c_MPQ_WORDS = NUM_MPQ / 32;
  localparam logic [1:0]  c_OKAY      = 2'b00;
  localparam logic [1:0]  c_SLVERR    = 2'b10;
  localparam logic [31:0] c_ERR_DATA  = 32'hFFFF_FFFF;

  typedef logic [UMATCH_ENTRIES-1:0][UMATCH_WIDTH-1:0] tbl_t;

  // Byte-lane merge used by every RW register (narrow registers are zero-extended first)
  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Registers
  logic [NUM_CLUSTERS-1:0] fetch_en_q, eoc_q, busy_q, sticky_q, irq_en_q;
  logic                    aux_rst_q, irq_q, valid_q, commit_q;
  logic [MODE_W-1:0]       mode_q;
  logic [NUM_MPQ-1:0]      mpq_q;
  logic [NUM_STDOUT-1:0]   stdout_valid_q;
  logic [3:0]              sh_q_unused_guard;
  tbl_t                    sh_q  [4];
  tbl_t                    act_q [4];
  logic                    bvalid_q, rvalid_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [31:0]             rdata_q;

  // Handshake
  logic w_wr_acc, w_ar_acc;
  assign w_wr_acc = s_axil_awvalid_i & s_axil_wvalid_i & ~bvalid_q & ~rst;
  assign w_ar_acc = s_axil_arvalid_i & ~rvalid_q & ~rst;

  assign s_axil_awready_o = w_wr_acc;
  assign s_axil_wready_o  = w_wr_acc;
  assign s_axil_arready_o = w_ar_acc;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rdata_o   = rdata_q;

  logic [31:0] w_wa, w_ra, w_wi, w_ri, w_wr_tbl, w_wdata;
  logic [23:0] w_wpg, w_rpg;
  assign w_wa  = 32'(s_axil_awaddr_i);
  assign w_ra  = 32'(s_axil_araddr_i);
  assign w_wpg = w_wa[31:8];
  assign w_rpg = w_ra[31:8];
  assign w_wi  = {26'd0, w_wa[7:2]};
  assign w_ri  = {26'd0, w_ra[7:2]};
  assign w_wdata = s_axil_wdata_i;

  // Protection bits and byte offsets carry no meaning for this block
  logic w_unused_ok;
  assign w_unused_ok = ^{s_axil_awprot_i, s_axil_arprot_i, w_wa[1:0], w_ra[1:0], sh_q_unused_guard};
  assign sh_q_unused_guard = 4'd0;

  // Write address decode: one-hot register selects plus an OKAY/SLVERR verdict
  logic w_wr_ok, w_wr_fetch, w_wr_aux, w_wr_clr, w_wr_irqen;
  logic w_wr_mode, w_wr_valid, w_wr_commit, w_wr_sh;
  always_comb begin
    w_wr_ok     = 1'b0;
    w_wr_fetch  = 1'b0;
    w_wr_aux    = 1'b0;
    w_wr_clr    = 1'b0;
    w_wr_irqen  = 1'b0;
    w_wr_mode   = 1'b0;
    w_wr_valid  = 1'b0;
    w_wr_commit = 1'b0;
    w_wr_sh     = 1'b0;
    w_wr_tbl    = 32'd0;
    if ({w_wa[31:2], 2'b00} == 32'h0000) begin
      w_wr_fetch = 1'b1; w_wr_ok = 1'b1;
    end else if ({w_wa[31:2], 2'b00} == 32'h0004) begin
      w_wr_aux = 1'b1; w_wr_ok = 1'b1;
    end else if ({w_wa[31:2], 2'b00} == 32'h0108) begin
      w_wr_clr = 1'b1; w_wr_ok = 1'b1;
    end else if ({w_wa[31:2], 2'b00} == 32'h010C) begin
      w_wr_irqen = 1'b1; w_wr_ok = 1'b1;
    end else if ({w_wa[31:2], 2'b00} == 32'h2000) begin
      w_wr_mode = 1'b1; w_wr_ok = 1'b1;
    end else if ({w_wa[31:2], 2'b00} == 32'h2004) begin
      w_wr_valid = 1'b1; w_wr_ok = 1'b1;
    end else if ({w_wa[31:2], 2'b00} == 32'h2008) begin
      w_wr_commit = 1'b1; w_wr_ok = 1'b1;
    end else if (w_wpg >= 24'h21 && w_wpg <= 24'h24 && w_wi < UMATCH_ENTRIES) begin
      w_wr_sh  = 1'b1; w_wr_ok = 1'b1;
      w_wr_tbl = 32'(w_wpg - 24'h21);
    end
  end

  // Read mux: unmapped reads answer all-ones with SLVERR; stdout pops are requested here
  logic [31:0]           w_rdata;
  logic [1:0]            w_rresp;
  logic [NUM_STDOUT-1:0] w_pop;
  always_comb begin
    w_rdata = c_ERR_DATA;
    w_rresp = c_SLVERR;
    w_pop   = '0;
    if ({w_ra[31:2], 2'b00} == 32'h0000) begin
      w_rdata = 32'(fetch_en_q); w_rresp = c_OKAY;
    end else if ({w_ra[31:2], 2'b00} == 32'h0004) begin
      w_rdata = 32'(aux_rst_q); w_rresp = c_OKAY;
    end else if ({w_ra[31:2], 2'b00} == 32'h0100) begin
      w_rdata = 32'(eoc_q); w_rresp = c_OKAY;
    end else if ({w_ra[31:2], 2'b00} == 32'h0104) begin
      w_rdata = 32'(busy_q); w_rresp = c_OKAY;
    end else if ({w_ra[31:2], 2'b00} == 32'h0108) begin
      w_rdata = 32'(sticky_q); w_rresp = c_OKAY;
    end else if ({w_ra[31:2], 2'b00} == 32'h010C) begin
      w_rdata = 32'(irq_en_q); w_rresp = c_OKAY;
    end else if (w_rpg == 24'h02 && w_ri < c_MPQ_WORDS) begin
      w_rresp = c_OKAY;
      for (int k = 0; k < c_MPQ_WORDS; k++)
        if (w_ri == k) w_rdata = mpq_q[k*32 +: 32];
    end else if (w_rpg == 24'h10 && w_ri < NUM_STDOUT) begin
      // The pop uses the live FIFO flags so data and pop refer to the same head entry
      w_rresp = c_OKAY;
      for (int c = 0; c < NUM_STDOUT; c++)
        if (w_ri == c && stdout_valid_i[c]) begin
          w_rdata  = stdout_dout_i[c*32 +: 32];
          w_pop[c] = 1'b1;
        end
    end else if ({w_ra[31:2], 2'b00} == 32'h1100) begin
      w_rdata = 32'(stdout_valid_q); w_rresp = c_OKAY;
    end else if ({w_ra[31:2], 2'b00} == 32'h2000) begin
      w_rdata = 32'(mode_q); w_rresp = c_OKAY;
    end else if ({w_ra[31:2], 2'b00} == 32'h2004) begin
      w_rdata = 32'(valid_q); w_rresp = c_OKAY;
    end else if ({w_ra[31:2], 2'b00} == 32'h2008) begin
      w_rdata = 32'd0; w_rresp = c_OKAY;
    end else if (w_rpg >= 24'h21 && w_rpg <= 24'h24 && w_ri < UMATCH_ENTRIES) begin
      w_rresp = c_OKAY;
      for (int t = 0; t < 4; t++)
        for (int e = 0; e < UMATCH_ENTRIES; e++)
          if (32'(w_rpg - 24'h21) == t && w_ri == e) w_rdata = 32'(sh_q[t][e]);
    end
  end

  assign stdout_rd_en_o = w_pop & {NUM_STDOUT{w_ar_acc}};

  // Write response channel: one outstanding write, response held until bready
  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= c_OKAY;
    end else if (w_wr_acc) begin
      bvalid_q <= 1'b1;
      bresp_q  <= w_wr_ok ? c_OKAY : c_SLVERR;
    end else if (bvalid_q && s_axil_bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read data channel: capture the mux at AR accept and hold until rready
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= c_OKAY;
    end else if (w_ar_acc) begin
      rvalid_q <= 1'b1;
      rdata_q  <= w_rdata;
      rresp_q  <= w_rresp;
    end else if (rvalid_q && s_axil_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  // Status sampling, EOC sticky (set beats clear) and registered interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      eoc_q          <= '0;
      busy_q         <= '0;
      mpq_q          <= '0;
      stdout_valid_q <= '0;
      sticky_q       <= '0;
      irq_q          <= 1'b0;
    end else begin
      eoc_q          <= cl_eoc_i;
      busy_q         <= cl_busy_i;
      mpq_q          <= mpq_full_i;
      stdout_valid_q <= stdout_valid_i;
      sticky_q       <= (sticky_q & ~((w_wr_acc && w_wr_clr)
                          ? NUM_CLUSTERS'(f_merge(32'd0, w_wdata, s_axil_wstrb_i))
                          : '0))
                        | (cl_eoc_i & ~eoc_q);
      irq_q          <= |(sticky_q & irq_en_q);
    end
  end

  // Control registers written over AXI-Lite
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_en_q <= '0;
      aux_rst_q  <= 1'b1;
      irq_en_q   <= '0;
      mode_q     <= '0;
      valid_q    <= 1'b0;
    end else if (w_wr_acc) begin
      if (w_wr_fetch) fetch_en_q <= NUM_CLUSTERS'(f_merge(32'(fetch_en_q), w_wdata, s_axil_wstrb_i));
      if (w_wr_aux)   aux_rst_q  <= f_merge(32'(aux_rst_q), w_wdata, s_axil_wstrb_i) != 32'd0;
      if (w_wr_irqen) irq_en_q   <= NUM_CLUSTERS'(f_merge(32'(irq_en_q), w_wdata, s_axil_wstrb_i));
      if (w_wr_mode)  mode_q     <= MODE_W'(f_merge(32'(mode_q), w_wdata, s_axil_wstrb_i));
      if (w_wr_valid) valid_q    <= f_merge(32'(valid_q), w_wdata, s_axil_wstrb_i) != 32'd0;
    end
  end

  // Match table: shadow writes, and a commit copies all shadows to the active set
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_q <= 1'b0;
      for (int t = 0; t < 4; t++) begin
        sh_q[t]  <= '0;
        act_q[t] <= '0;
      end
    end else begin
      commit_q <= w_wr_acc && w_wr_commit && s_axil_wstrb_i[0] && w_wdata[0];
      if (w_wr_acc && w_wr_commit && s_axil_wstrb_i[0] && w_wdata[0]) begin
        for (int t = 0; t < 4; t++) act_q[t] <= sh_q[t];
      end
      for (int t = 0; t < 4; t++)
        for (int e = 0; e < UMATCH_ENTRIES; e++)
          if (w_wr_acc && w_wr_sh && w_wr_tbl == t && w_wi == e)
            sh_q[t][e] <= UMATCH_WIDTH'(f_merge(32'(sh_q[t][e]), w_wdata, s_axil_wstrb_i));
    end
  end

  assign cl_fetch_en_o = fetch_en_q;
  assign aux_rst_o     = aux_rst_q;
  assign irq_o         = irq_q;
  assign match_mode_o  = mode_q;
  // Consumers see the table as invalid for the one cycle in which it is swapped
  assign match_valid_o = valid_q & ~commit_q;
  assign match_idx_o   = act_q[0];
  assign match_mask_o  = act_q[1];
  assign match_start_o = act_q[2];
  assign match_end_o   = act_q[3];

endmodule
`default_nettype wire

// File: tb/tb_pspin_ctrl_csr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pspin_ctrl_csr
// Brief    : Directed scoreboard bench for pspin_ctrl_csr (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pspin_ctrl_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [1:0]  fetch_en, eoc, busy, rd_en, sval;
  logic        aux_rst, irq, mvalid;
  logic [0:0]  mmode;
  logic [255:0] mpq;
  logic [63:0] dout;
  logic [511:0] midx, mmask, mstart, mend;

  int n_chk  = 0;
  int n_fail = 0;
  int pcnt   = 0;
  logic [1:0] plast;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  pspin_ctrl_csr dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(3'b000), .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(3'b000), .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready),
    .cl_fetch_en_o(fetch_en), .aux_rst_o(aux_rst), .irq_o(irq),
    .cl_eoc_i(eoc), .cl_busy_i(busy), .mpq_full_i(mpq),
    .stdout_rd_en_o(rd_en), .stdout_dout_i(dout), .stdout_valid_i(sval),
    .match_mode_o(mmode), .match_valid_o(mvalid),
    .match_idx_o(midx), .match_mask_o(mmask), .match_start_o(mstart), .match_end_o(mend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: compare every completed R/B handshake against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
        else chk("r_resp", {30'd0, rdata, rresp}, {30'd0, rq.pop_front()});
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else chk("b_resp", {62'd0, bresp}, {62'd0, bq.pop_front()});
      end
    end
  end

  // stdout pop observer
  always @(negedge clk) begin
    if (rd_en != 2'b00) begin
      pcnt  = pcnt + 1;
      plast = rd_en;
    end
  end

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      done = (rq.size() == 0) && (bq.size() == 0);
    end
    if (!done) begin
      chk("drain_timeout", 64'd0, 64'd1);
      rq.delete();
      bq.delete();
    end
    #1;
  endtask

  task automatic ar_wait();
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = arready;
    end
    if (!got) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic ar_issue(input logic [15:0] a);
    araddr  = a;
    arvalid = 1'b1;
    ar_wait();
  endtask

  task automatic aw_issue(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = awready && wready;
    end
    if (!got) chk("aw_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] d, input logic [1:0] r);
    rq.push_back({d, r});
    ar_issue(a);
    drain();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] r);
    bq.push_back(r);
    aw_issue(a, d, s);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
    wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    eoc = '0; busy = '0; mpq = '0; dout = '0; sval = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {58'd0, aux_rst, irq, fetch_en, mvalid, bvalid}, {58'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0});
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    rst = 1'b0;

    // Reset values over the bus
    rd(16'h0004, 32'h1, 2'b00);
    rd(16'h0000, 32'h0, 2'b00);

    // Byte strobes and RO write protection
    wr(16'h0000, 32'hFFFF_FFFF, 4'h1, 2'b00);
    chk("fetch_en_out", {62'd0, fetch_en}, 64'd3);
    wr(16'h0000, 32'h0000_0000, 4'hE, 2'b00);
    rd(16'h0000, 32'h3, 2'b00);
    wr(16'h0100, 32'h3, 4'hF, 2'b10);
    rd(16'h0100, 32'h0, 2'b00);

    // Busy and MPQ status sampling
    busy = 2'b10; mpq[33] = 1'b1;
    @(posedge clk); #1;
    rd(16'h0104, 32'h2, 2'b00);
    rd(16'h0204, 32'h2, 2'b00);
    rd(16'h0220, 32'hFFFF_FFFF, 2'b10);

    // EOC sticky and interrupt
    wr(16'h010C, 32'h1, 4'hF, 2'b00);
    eoc = 2'b01;
    repeat (2) @(posedge clk); #1;
    rd(16'h0100, 32'h1, 2'b00);
    eoc = 2'b00;
    repeat (2) @(posedge clk); #1;
    rd(16'h0108, 32'h1, 2'b00);
    chk("irq_set", {63'd0, irq}, 64'd1);
    wr(16'h0108, 32'h1, 4'hF, 2'b00);
    chk("irq_cleared", {63'd0, irq}, 64'd0);
    rd(16'h0108, 32'h0, 2'b00);
    // Rising edge in the very cycle the clear is accepted
    bq.push_back(2'b00);
    eoc = 2'b01;
    aw_issue(16'h0108, 32'h1, 4'hF);
    drain();
    eoc = 2'b00;
    rd(16'h0108, 32'h1, 2'b00);
    chk("irq_reset_by_edge", {63'd0, irq}, 64'd1);

    // stdout pops
    sval = 2'b10; dout = {32'h0000_0041, 32'h0000_0099};
    @(posedge clk); #1;
    p0 = pcnt;
    rd(16'h1004, 32'h41, 2'b00);
    chk("pop_count", 64'(pcnt - p0), 64'd1);
    chk("pop_lane", {62'd0, plast}, 64'd2);
    rd(16'h1100, 32'h2, 2'b00);
    sval = 2'b00;
    @(posedge clk); #1;
    p0 = pcnt;
    rd(16'h1004, 32'hFFFF_FFFF, 2'b00);
    chk("no_pop", 64'(pcnt - p0), 64'd0);

    // Match table: shadow, commit, valid gap
    wr(16'h2004, 32'h1, 4'hF, 2'b00);
    chk("mvalid_on", {63'd0, mvalid}, 64'd1);
    wr(16'h2100, 32'h0000_ABCD, 4'hF, 2'b00);
    chk("idx_not_live", {32'd0, midx[31:0]}, 64'd0);
    rd(16'h2100, 32'h0000_ABCD, 2'b00);
    bq.push_back(2'b00);
    aw_issue(16'h2008, 32'h1, 4'hF);
    chk("commit_idx", {32'd0, midx[31:0]}, 64'h0000_ABCD);
    chk("commit_valid_gap", {63'd0, mvalid}, 64'd0);
    drain();
    chk("valid_after_commit", {63'd0, mvalid}, 64'd1);
    wr(16'h2204, 32'h1234, 4'hF, 2'b00);
    wr(16'h2008, 32'h0, 4'hF, 2'b00);
    chk("no_commit", {32'd0, mmask[63:32]}, 64'd0);
    rd(16'h2008, 32'h0, 2'b00);
    wr(16'h2000, 32'h3, 4'hF, 2'b00);
    chk("mode_out", {63'd0, mmode}, 64'd1);
    rd(16'h2000, 32'h1, 2'b00);

    // Unmapped access, with the read response back-pressured
    wr(16'h3000, 32'h5, 4'hF, 2'b10);
    rready = 1'b0;
    rq.push_back({32'hFFFF_FFFF, 2'b10});
    ar_issue(16'h3000);
    rq.push_back({32'h3, 2'b00});
    araddr = 16'h0000; arvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("r_hold", {28'd0, rvalid, arready, rdata, rresp}, {28'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'b10});
    end
    @(posedge clk); #1 rready = 1'b1;
    ar_wait();
    drain();

    // Reset in the middle of a read
    rready = 1'b0;
    ar_issue(16'h0004);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_drop_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_regs", {60'd0, aux_rst, fetch_en, mvalid}, {60'd0, 1'b1, 2'b00, 1'b0});
    rst = 1'b0; rready = 1'b1;
    rd(16'h0000, 32'h0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pspin_ctrl_csr.md
PSPIN_CTRL_CSR -- requirements
Module: pspin_ctrl_csr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, AXI-Lite byte address width.
REQ-002 SHALL have parameter NUM_CLUSTERS, default 2, cluster count (1..32).
REQ-003 SHALL have parameter NUM_MPQ, default 256, MPQ count (multiple of 32, max 1024).
REQ-004 SHALL have parameter NUM_STDOUT, default 2, stdout FIFO channels (1..8).
REQ-005 SHALL have parameters UMATCH_WIDTH 32, UMATCH_ENTRIES 16 (max 64), UMATCH_MODES 2; data width is fixed at 32.
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have a full AXI-Lite slave s_axil_* (aw/w/b/ar/r channels, 32-bit data, 4-bit strobe, 2-bit resp).
REQ-008 SHALL have outputs cl_fetch_en_o NUM_CLUSTERS, aux_rst_o 1, irq_o 1.
REQ-009 SHALL have inputs cl_eoc_i NUM_CLUSTERS, cl_busy_i NUM_CLUSTERS, mpq_full_i NUM_MPQ.
REQ-010 SHALL have stdout_rd_en_o out NUM_STDOUT, stdout_dout_i in 32*NUM_STDOUT, stdout_valid_i in NUM_STDOUT.
REQ-011 SHALL have outputs match_mode_o clog2(UMATCH_MODES), match_valid_o 1, match_idx_o/mask_o/start_o/end_o UMATCH_WIDTH*UMATCH_ENTRIES each.

Function
REQ-012 SHALL map: 0x0000 fetch_en RW; 0x0004 aux_rst RW; 0x0100 eoc RO; 0x0104 busy RO; 0x0108 eoc_sticky W1C; 0x010C irq_en RW; 0x0200+4k mpq_full word k RO; 0x1000+4c stdout pop ch c RO; 0x1100 stdout_valid RO; 0x2000 mode RW; 0x2004 valid RW; 0x2008 commit WO; 0x2100/0x2200/0x2300/0x2400+4e idx/mask/start/end shadow entry e RW.
REQ-013 SHALL accept AW and W only together, one write outstanding; awready=wready=1 for exactly the cycle both valid and bvalid low.
REQ-014 SHALL assert bvalid the cycle after acceptance, hold it with bresp stable until bready.
REQ-015 SHALL accept AR (arready pulse) only while rvalid low; rvalid the cycle after, rdata/rresp held until rready.
REQ-016 Read and write paths SHALL operate concurrently and independently.
REQ-017 RW writes SHALL honour wstrb per byte; bits above a register's defined width read 0.
REQ-018 Read of unmapped address SHALL return 0xFFFFFFFF, rresp SLVERR (2'b10).
REQ-019 Write to unmapped or RO address SHALL leave all state unchanged, bresp SLVERR; other accesses OKAY.
REQ-020 eoc_sticky[n] SHALL set on rising edge of cl_eoc_i[n] (registered previous value); writing 1 clears; set wins over simultaneous clear.
REQ-021 irq_o SHALL be registered |(eoc_sticky & irq_en), one cycle after sticky/enable change.
REQ-022 eoc, busy, mpq_full, stdout_valid SHALL be sampled into registers every cycle; reads return the sampled value.
REQ-023 Read of stdout ch c with stdout_valid_i[c]=1 SHALL return stdout_dout_i[c] and pulse stdout_rd_en_o[c] for exactly one cycle (the AR accept cycle); with valid 0, return 0xFFFFFFFF, OKAY, no pulse.
REQ-024 Match-table writes SHALL update shadow registers only; match_*_o outputs unchanged.
REQ-025 Write of bit0=1 to commit SHALL copy all shadows to match_idx/mask/start/end_o in one cycle, visible the cycle after write acceptance; bit0=0 no effect; commit reads 0.
REQ-026 match_valid_o SHALL be forced 0 during the commit cycle, then return to valid register value.
REQ-027 mode and valid registers SHALL drive match_mode_o/match_valid_o directly (no shadow).

Reset
REQ-028 On rst: aux_rst_o=1, all other registers, shadows, outputs, sticky, irq_o, stdout_rd_en_o, bvalid, rvalid = 0; awready/wready/arready 0.
REQ-029 rst mid-transaction SHALL drop bvalid/rvalid without response; transactions pending are discarded.

Verification
REQ-030 Reset, read 0x0004 -> 0x00000001 OKAY; read 0x0000 -> 0x00000000.
REQ-031 Write 0x0000=0xFFFFFFFF strb 0x1, NUM_CLUSTERS=2 -> cl_fetch_en_o=2'b11, readback 0x00000003; write 0x0100 -> SLVERR, eoc unchanged.
REQ-032 irq_en=1, pulse cl_eoc_i[0] -> 0x0108 reads 1, irq_o=1; write 0x0108=1 -> irq_o=0 within 2 cycles; edge coincident with clear -> sticky stays 1.
REQ-033 stdout ch1 valid, dout=0x41 -> read 0x1004 returns 0x41, stdout_rd_en_o=2'b10 one cycle; valid 0 -> 0xFFFFFFFF, no pulse.
REQ-034 Write 0x2100=0xABCD -> match_idx_o[31:0] still 0; write 0x2008=1 -> 0xABCD next cycle, match_valid_o low that cycle.
REQ-035 Read 0x3000 -> 0xFFFFFFFF SLVERR; rready held low 5 cycles -> rdata stable, no new arready.
